delay_pipe_scheduler: RTL

- Round-robin scheduler that shares one fixed-latency datapath among NUM_REQ requesters. The datapath is a chain of PIPE_STAGES 1-bit single-stage valid registers plus matching data registers.
- The block grants at most one requester per cycle. It carries the requester ID through a tag pipeline that runs in lockstep with the datapath, and returns each result tagged with its owner.
- Sits between the PE request ports and the shared compute/delay pipeline in the accelerator datapath.

---
 rtl/delay_pipe_scheduler_pkg.sv | 25 ++
 rtl/delay_pipe_scheduler_rr_priority_arbiter.sv | 31 +++
 rtl/delay_pipe_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/delay_pipe_scheduler_pkg.sv
// Shared definitions for the delay pipe scheduler: width helpers, legal
// parameter ranges and the tag record carried alongside the datapath.
package delay_pipe_scheduler_pkg;

  localparam int NUM_REQ_MIN     = 2;
  localparam int NUM_REQ_MAX     = 16;
  localparam int PIPE_STAGES_MIN = 1;
  localparam int PIPE_STAGES_MAX = 32;

  // Ceiling log2, floored at 1 so a width is never zero.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int TAG_ID_W = clog2_f(NUM_REQ_MAX);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/delay_pipe_scheduler_rr_priority_arbiter.sv
// Combinational rotating-priority arbiter: the first set request at or
// after ptr (ascending, modulo NUM_REQ) wins.
module rr_priority_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/delay_pipe_scheduler.sv
// Round-robin scheduler sharing a fixed-latency pipeline among NUM_REQ
// requesters. Optional feature macro: DELAY_PIPE_SCHED_ONE_OUTSTANDING_EN.
module delay_pipe_scheduler
  import delay_pipe_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 3,
  parameter int ID_W        = clog2_f(NUM_REQ),
  parameter int CNT_W       = clog2_f(PIPE_STAGES + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               PIPE_EN,
  output logic [NUM_REQ-1:0] GNT,
  output logic               ISSUE_VALID,
  output logic [ID_W-1:0]    ISSUE_ID,
  output logic               RESULT_VALID,
  output logic [ID_W-1:0]    RESULT_ID,
  output logic [CNT_W-1:0]   INFLIGHT,
`ifdef DELAY_PIPE_SCHED_ONE_OUTSTANDING_EN
  output logic [NUM_REQ-1:0] PENDING,
`endif
  output logic               BUSY
);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
      PIPE_STAGES < PIPE_STAGES_MIN || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_range
    $error("delay_pipe_scheduler: parameter out of range");
  end

  logic [NUM_REQ-1:0] req_elig;
  logic [NUM_REQ-1:0] arb_req;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    ptr;
  logic               grant_any;
  logic [CNT_W-1:0]   inflight_q;
  tag_t               tag_p [PIPE_STAGES];
  logic               unused_tag_hi;

  assign ISSUE_VALID   = tag_p[0].valid & PIPE_EN & ~RESET;
  assign RESULT_VALID  = tag_p[PIPE_STAGES-1].valid & PIPE_EN & ~RESET;
  assign ISSUE_ID      = tag_p[0].id[ID_W-1:0];
  assign RESULT_ID     = tag_p[PIPE_STAGES-1].id[ID_W-1:0];
  assign unused_tag_hi = ^tag_p[PIPE_STAGES-1];

`ifdef DELAY_PIPE_SCHED_ONE_OUTSTANDING_EN
  logic [NUM_REQ-1:0] pend_q;

  // A requester whose result drains this cycle is eligible again right away.
  always_comb begin
    req_elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_elig[i] = REQ[i] & (~pend_q[i] | (RESULT_VALID & (RESULT_ID == ID_W'(i))));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (GNT[i])
          pend_q[i] <= 1'b1;
        else if (RESULT_VALID && (RESULT_ID == ID_W'(i)))
          pend_q[i] <= 1'b0;
      end
    end
  end

  assign PENDING = pend_q;
`else
  assign req_elig = REQ;
`endif

  assign arb_req = req_elig & {NUM_REQ{PIPE_EN & ~RESET}};

  rr_priority_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (arb_req),
    .ptr    (ptr),
    .gnt    (GNT),
    .winner (winner)
  );

  assign grant_any = |GNT;

  always_ff @(posedge CLK) begin
    if (RESET)
      ptr <= '0;
    else if (grant_any)
      ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // Tag pipeline: stage 0 loads the grant, later stages shift on advance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < PIPE_STAGES; k++) tag_p[k] <= '0;
    end else if (PIPE_EN) begin
      tag_p[0].valid <= grant_any;
      tag_p[0].id    <= grant_any ? TAG_ID_W'(winner) : '0;
      for (int k = 1; k < PIPE_STAGES; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  // A full pipeline may still grant: the last stage drains on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET)
      inflight_q <= '0;
    else if (grant_any && !RESULT_VALID)
      inflight_q <= inflight_q + CNT_W'(1);
    else if (!grant_any && RESULT_VALID)
      inflight_q <= inflight_q - CNT_W'(1);
  end

  assign INFLIGHT = inflight_q;
  assign BUSY     = (inflight_q != '0);

endmodule
